// File: rtl/posit_pack.sv
// posit_pack: serialises a decoded (sign, regime, exponent, fraction) tuple into
// a posit<8,EN> word, one stream bit per clock, with round-to-nearest-even.
module posit_pack #(
    parameter int EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic signed [7:0] regime,
    input  logic signed [7:0] exponent,
    input  logic [7:0]        mantissa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        posit
);

    typedef enum logic [1:0] {IDLE, EMIT, ROUND, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] stream_q, stream_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sticky_q, sticky_d;
    logic        sign_q, sign_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  posit_q, posit_d;

    logic [31:0] pat, tail, stream_in;
    logic [33:0] tail_w;
    logic [5:0]  rlen;
    logic [7:0]  neg_k;
    logic [6:0]  body;
    logic        round_up;
    logic [7:0]  mag;
    logic        unused_bits;

    assign unused_bits = ^{exponent[7:2], neg_k[7:6]};

    // Left-aligned stream: regime run, then exponent LSBs, then fraction.
    always_comb begin
        neg_k  = -regime;
        tail_w = {exponent[1:0], mantissa, 24'b0} << (2 - EN);
        tail   = tail_w[33:2];
        if (!regime[7]) begin
            pat  = ~(32'hFFFF_FFFF >> ({3'b0, regime[2:0]} + 6'd1));
            rlen = {3'b0, regime[2:0]} + 6'd2;
        end else begin
            pat  = 32'h8000_0000 >> neg_k[5:0];
            rlen = neg_k[5:0] + 6'd1;
        end
        stream_in = pat | (tail >> rlen);
    end

    always_comb begin
        body     = acc_q[7:1];
        round_up = acc_q[0] & (body[0] | sticky_q) & (body != 7'h7F);
        mag      = {1'b0, body + {6'b0, round_up}};
    end

    always_comb begin
        state_d     = state_q;
        stream_d    = stream_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        sign_d      = sign_q;
        posit_d     = posit_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign;
                    if ($unsigned(regime) == 8'h80) begin
                        posit_d = '0;
                        state_d = HOLD;
                    end else if (regime >= 8'sd6) begin
                        posit_d = sign ? 8'h81 : 8'h7F;
                        state_d = HOLD;
                    end else if (regime <= -8'sd7) begin
                        posit_d = sign ? 8'hFF : 8'h01;
                        state_d = HOLD;
                    end else begin
                        stream_d = stream_in;
                        acc_d    = '0;
                        cnt_d    = '0;
                        sticky_d = 1'b0;
                        state_d  = EMIT;
                    end
                end
            end
            EMIT: begin
                acc_d    = {acc_q[6:0], stream_q[31]};
                stream_d = {stream_q[30:0], 1'b0};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    sticky_d = |stream_q[30:0];
                    state_d  = ROUND;
                end
            end
            ROUND: begin
                posit_d = sign_q ? (~mag + 8'd1) : mag;
                state_d = HOLD;
            end
            HOLD: begin
                // out_valid is registered, so the first HOLD cycle is a settle cycle.
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stream_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            posit_q     <= '0;
        end else begin
            state_q     <= state_d;
            stream_q    <= stream_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            posit_q     <= posit_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign posit     = posit_q;

endmodule

// File: tb/tb_posit_pack.sv
// Scoreboard bench for posit_pack (EN=1): expected words are queued at drive time
// and popped when the block presents its result.
module tb_posit_pack;

    localparam int TB_EN = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              sign = 1'b0;
    logic signed [7:0] regime = '0;
    logic signed [7:0] exponent = '0;
    logic [7:0]        mantissa = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        posit;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    posit_pack #(.EN(TB_EN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .regime(regime), .exponent(exponent), .mantissa(mantissa),
        .out_valid(out_valid), .out_ready(out_ready), .posit(posit)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit-by-bit reference encoder.
    function automatic logic [7:0] model(input logic s, input int k, input logic [1:0] e,
                                         input logic [7:0] m);
        bit         bits[32];
        int         n;
        logic [6:0] b;
        logic [7:0] v;
        logic       g, st;
        if (k == -128) return 8'h00;
        if (k >= 6) return s ? 8'h81 : 8'h7F;
        if (k <= -7) return s ? 8'hFF : 8'h01;
        for (int i = 0; i < 32; i++) bits[i] = 1'b0;
        n = 0;
        if (k >= 0) begin
            for (int i = 0; i <= k; i++) begin bits[n] = 1'b1; n++; end
            bits[n] = 1'b0; n++;
        end else begin
            for (int i = 0; i < -k; i++) begin bits[n] = 1'b0; n++; end
            bits[n] = 1'b1; n++;
        end
        for (int i = TB_EN - 1; i >= 0; i--) begin bits[n] = e[i]; n++; end
        for (int i = 7; i >= 0; i--) begin bits[n] = m[i]; n++; end
        for (int i = 0; i < 7; i++) b[6-i] = bits[i];
        g  = bits[7];
        st = 1'b0;
        for (int i = 8; i < 32; i++) st = st | bits[i];
        if (g && (b[0] || st) && b != 7'h7F) b = b + 7'd1;
        v = {1'b0, b};
        return s ? (8'd0 - v) : v;
    endfunction

    task automatic send(input logic s, input int k, input logic [1:0] e, input logic [7:0] m,
                        input logic [7:0] expv);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("in_ready_before_send", in_ready, 1);
        sign     = s;
        regime   = 8'(k);
        exponent = {6'b0, e};
        mantissa = m;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge just after the acceptance edge.
    task automatic receive(input string tag, input int exp_lat);
        int lat = 0;
        logic [7:0] expv;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            expv = exp_q.pop_front();
            check(tag, posit, expv);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int         k;
        logic       s;
        logic [1:0] e;
        logic [7:0] m, held;
        int         seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_posit", posit, 8'h00);
        rst_n = 1'b1;

        send(1'b0, 0, 2'd0, 8'h00, 8'h40); receive("one", 10);
        send(1'b1, 0, 2'd0, 8'h00, 8'hC0); receive("minus_one", 10);
        send(1'b0, 0, 2'd1, 8'h80, 8'h58); receive("three", 10);
        send(1'b0, 0, 2'd0, 8'h08, 8'h40); receive("tie_even", 10);
        send(1'b0, 0, 2'd0, 8'h18, 8'h42); receive("tie_odd", 10);
        send(1'b0, 0, 2'd0, 8'h09, 8'h41); receive("sticky_up", 10);
        send(1'b1, -128, 2'd1, 8'hFF, 8'h00); receive("zero", 1);
        send(1'b0, 7, 2'd0, 8'h00, 8'h7F); receive("maxpos", 1);
        send(1'b1, -8, 2'd0, 8'h00, 8'hFF); receive("neg_minpos", 1);
        send(1'b0, 6, 2'd1, 8'h55, 8'h7F); receive("k6_sat", 1);
        send(1'b0, -7, 2'd1, 8'hAA, 8'h01); receive("km7_sat", 1);
        send(1'b0, 5, 2'd1, 8'hFF, 8'h7F); receive("k5_no_wrap", 10);
        send(1'b0, -6, 2'd0, 8'h00, 8'h01); receive("km6_min", 10);
        send(1'b1, 5, 2'd0, 8'h00, 8'h82); receive("k5_neg", 10);

        // Backpressure: result must hold, and a new operand must be ignored.
        send(1'b0, 0, 2'd1, 8'h80, 8'h58);
        seen = 0;
        while (!out_valid && seen < 40) begin @(posedge clk); @(negedge clk); seen++; end
        check("bp_latency", seen, 10);
        held = exp_q.pop_front();
        sign = 1'b1; regime = 8'sd1; exponent = 8'sd1; mantissa = 8'hF0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_posit", posit, held);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp_ignored_in_ready", in_ready, 1);
        check("bp_ignored_valid", out_valid, 0);

        // Reset on the 4th EMIT edge discards the operand.
        send(1'b0, 1, 2'd1, 8'h33, model(1'b0, 1, 2'd1, 8'h33));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_posit", posit, 8'h00);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_valid", seen, 0);
        send(1'b0, 0, 2'd1, 8'h80, 8'h58); receive("after_rst", 10);

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            k = (i % 10 == 3) ? -128 : int'($urandom_range(0, 15)) - 8;
            e = 2'($urandom_range(0, 1));
            m = 8'($urandom_range(0, 255));
            send(s, k, e, m, model(s, k, e, m));
            receive("random", (k == -128 || k >= 6 || k <= -7) ? 1 : 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/posit_pack.md
POSIT_PACK -- requirements
Module: posit_pack

Interface
REQ-001 SHALL have parameter EN, default 1, meaning exponent field width es; legal values 0..2.
REQ-002 SHALL fix the posit width at 8 bits (sign + 7-bit body).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operand present.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-007 SHALL have port sign, input, 1, sign of the value (1 = negative).
REQ-008 SHALL have port regime, input signed, 8, regime k; 8'h80 flags exact zero.
REQ-009 SHALL have port exponent, input signed, 8, exponent in 0..2^EN-1; only its EN LSBs are used.
REQ-010 SHALL have port mantissa, input, 8, fraction bits left-aligned with the hidden 1 already stripped.
REQ-011 SHALL have port out_valid, output, 1, posit result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port posit, output, 8, packed posit<8,EN> result.

Function
REQ-014 SHALL implement states IDLE, EMIT, ROUND and HOLD.
REQ-015 SHALL assert in_ready only in IDLE; an operand is accepted on an edge where in_valid && in_ready.
REQ-016 SHALL ignore in_valid in every state other than IDLE.
REQ-017 On acceptance, SHALL latch all inputs and build the bit stream {regime field, exponent[EN-1:0], mantissa[7:0], zeros}.
REQ-018 Regime field: k>=0 gives (k+1) ones then a zero; k<0 gives (-k) zeros then a one.
REQ-019 Normal path: IDLE->EMIT, shifting one stream bit per edge for 8 edges (7 body bits, then guard); sticky = OR of all stream bits after guard.
REQ-020 After the 8th EMIT edge, SHALL go EMIT->ROUND, then ROUND->HOLD.
REQ-021 ROUND SHALL apply round-to-nearest-even: increment the body if guard && (body LSB || sticky).
REQ-022 An increment SHALL never carry past 7'h7F.
REQ-023 ROUND SHALL take the two's complement of {0,body} when sign=1.
REQ-024 Normal latency: acceptance at edge 0, out_valid high after edge 10.
REQ-025 Special path: zero (regime==8'h80) gives 8'h00, sign ignored.
REQ-026 Special path: k>=6 saturates to maxpos 8'h7F (8'h81 if negative).
REQ-027 Special path: k<=-7 saturates to minpos 8'h01 (8'hFF if negative); a nonzero value SHALL never encode to 0.
REQ-028 Special paths SHALL go IDLE->HOLD directly, with out_valid high after edge 1.
REQ-029 HOLD SHALL keep out_valid=1 and posit stable until out_ready=1; HOLD->IDLE on that edge.
REQ-030 SHALL NOT accept a new operand on the same edge the result is consumed; in_ready rises the following cycle.
REQ-031 SHALL assert out_valid only in HOLD.

Reset
REQ-032 While rst_n=0 at a rising edge: state=IDLE, out_valid=0, posit=8'h00, in_ready=1 after that edge.
REQ-033 Reset in any state, including mid-EMIT or in HOLD, SHALL discard the operand in flight with no result emitted.
REQ-034 All internal shift, sticky and count registers SHALL clear on reset.

Verification
REQ-035 EN=1, sign=0, k=0, e=0, mantissa=8'h00 -> posit=8'h40, out_valid high exactly 10 edges after acceptance; same with sign=1 -> 8'hC0.
REQ-036 EN=1, k=0, e=1, mantissa=8'h80 (3.0) -> 8'h58.
REQ-037 Rounding, EN=1, k=0, e=0: mantissa=8'h08 -> 8'h40 (tie, even, round down); mantissa=8'h18 -> 8'h42 (tie, odd, round up); mantissa=8'h09 -> 8'h41 (sticky rounds up).
REQ-038 Special values: regime=8'h80 -> 8'h00; k=7 -> 8'h7F; k=-8, sign=1 -> 8'hFF; each with out_valid high 1 edge after acceptance.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> posit stable, in_ready=0 and new in_valid ignored; on the out_ready=1 edge go to IDLE, in_ready=1 the next cycle.
REQ-040 Reset at the 4th EMIT edge -> IDLE, out_valid never asserted, the next operand is encoded correctly.
